// File: rtl/uart_rx_byte_pkg.sv
// rtl/uart_rx_byte_pkg.sv - shared UART state encodings and bit-timing defaults
package uart_rx_byte_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rxState_e;

    localparam int CLKS_PER_BIT_57600 = 1736;

    function automatic int halfBit(input int clksPerBit);
        return clksPerBit / 2;
    endfunction

endpackage

// File: rtl/uart_rx_byte_if.sv
// rtl/uart_rx_byte_if.sv - received-byte valid/ready handshake
interface uart_rx_byte_if;

    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;

    modport master (output rx_data, output rx_valid, input rx_ready);
    modport slave  (input rx_data, input rx_valid, output rx_ready);

endinterface

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - rx line synchroniser, fall-edge detect and 3-sample majority
module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic CLK,
    input  logic reset,
    input  logic rxPin,
    output logic syncBit,
    output logic fallEdge,
    output logic majority
);

    logic [SYNC_STAGES-1:0] chain;
    logic [2:0]             hist;

    // Everything resets to the idle level so reset release never looks like a start edge.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            chain <= '1;
            hist  <= 3'b111;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], rxPin};
            hist  <= {hist[1:0], chain[SYNC_STAGES-1]};
        end
    end

    assign syncBit  = chain[SYNC_STAGES-1];
    assign fallEdge = hist[0] & ~syncBit;
    assign majority = (hist[0] & hist[1]) | (hist[0] & hist[2]) | (hist[1] & hist[2]);

endmodule

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - 8N1 UART receiver with byte handshake; RX_PARITY_EN adds even parity
module uart_rx_byte
    import uart_rx_byte_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_57600,
    parameter int SYNC_STAGES  = 2
) (
    input  logic          CLK,
    input  logic          reset,
    input  logic          rx_pin,
    uart_rx_byte_if.master rx,
    output logic          frame_err,
    output logic          overrun,
    input  logic          err_clr,
    output logic          busy
);

    localparam int            HALF      = halfBit(CLKS_PER_BIT);
    localparam int            CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] SAMPLE_AT = CW'(HALF + 1);
    localparam logic [CW-1:0] LAST      = CW'(CLKS_PER_BIT - 1);

    rxState_e      state;
    logic [CW-1:0] cnt;
    logic [2:0]    bitIdx;
    logic [7:0]    shreg;
    logic          armed;
    logic          syncBit, fallEdge, majority;
    logic          sampleNow, stopOk, deliver, canLoad;
`ifdef RX_PARITY_EN
    logic          parErr;
`endif

    uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .CLK      (CLK),
        .reset    (reset),
        .rxPin    (rx_pin),
        .syncBit  (syncBit),
        .fallEdge (fallEdge),
        .majority (majority)
    );

    always_comb begin
        sampleNow = (cnt == SAMPLE_AT);
`ifdef RX_PARITY_EN
        stopOk    = majority & ~parErr;
`else
        stopOk    = majority;
`endif
        deliver   = (state == STOP) && sampleNow && stopOk;
        canLoad   = ~rx.rx_valid | rx.rx_ready;
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            bitIdx      <= '0;
            shreg       <= '0;
            armed       <= 1'b0;
            rx.rx_data  <= '0;
            rx.rx_valid <= 1'b0;
            frame_err   <= 1'b0;
            overrun     <= 1'b0;
            busy        <= 1'b0;
`ifdef RX_PARITY_EN
            parErr      <= 1'b0;
`endif
        end else begin
            frame_err <= 1'b0;
            cnt       <= (cnt == LAST) ? '0 : cnt + 1'b1;
            if (rx.rx_valid && rx.rx_ready) rx.rx_valid <= 1'b0;
            if (err_clr) overrun <= 1'b0;
            // A set later in the block overrides err_clr in the same cycle.
            if (deliver) begin
                if (canLoad) begin
                    rx.rx_data  <= shreg;
                    rx.rx_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    // armed requires the line seen high first, so a break cannot retrigger.
                    if (fallEdge && armed) begin
                        state <= START;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        armed <= 1'b0;
                    end else if (syncBit) begin
                        armed <= 1'b1;
                    end
                end
                START: begin
                    if (sampleNow) begin
                        if (majority) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state  <= DATA;
                            bitIdx <= '0;
                        end
                    end
                end
                DATA: begin
                    if (sampleNow) begin
                        shreg  <= {majority, shreg[7:1]};
                        bitIdx <= bitIdx + 3'd1;
                        if (bitIdx == 3'd7) begin
`ifdef RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end
                end
`ifdef RX_PARITY_EN
                PARITY: begin
                    if (sampleNow) begin
                        parErr <= ^shreg ^ majority;
                        state  <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (sampleNow) begin
                        if (!stopOk) frame_err <= 1'b1;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
